multicycle_ctrl_fsm: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the shared PC/IR/register-file/ALU/memory datapath that decode_unit feeds. It takes decoded opcode/funct fields plus the branch comparator result and drives every datapath control strobe each cycle. It waits on a memory ready handshake and aborts with a bus-error pulse if memory stalls past a limit.

---
 rtl/multicycle_ctrl_fsm.sv | 272 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Main control FSM for the multicycle RV32I core. It sequences the shared
// PC/IR/register-file/ALU/memory datapath from the decoded opcode/funct fields
// and the branch comparator. Memory states wait on mem_ready. If memory stalls
// for WAIT_LIMIT cycles, the FSM pulses bus_err and returns to FETCH.
//
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   : an unsupported opcode parks the FSM in TRAP and raises a
//               sticky 'illegal' output until reset
//   undefined : an unsupported opcode retires as a no-op
//
// Ports
//   clk, reset               clock, async active-high reset
//   opcode/funct3/funct7     decoded instruction fields (stable per instruction)
//   Cond_Chk                 branch comparator result
//   mem_ready                memory access completes this cycle
//   IorD, MemWrite, MtoR, IRWrite, AluSrcA, AluSrcB, RegWrite,
//   Branch, PCWrite, PCEn, AluControl   datapath strobes
//   state_o                  current state (debug)
//   instr_done               pulse on the last cycle of an instruction
//   bus_err                  pulse on a memory timeout
//   illegal                  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only)
//
// state  | code | meaning
// FETCH  |  0   | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE |  1   | compute branch/jump target, dispatch on opcode
// MEMADR |  2   | rs1 + imm -> memory address
// MEMRD  |  3   | load access, wait for mem_ready
// MEMWR  |  4   | store access, wait for mem_ready
// MEMWB  |  5   | load data -> rd
// EXECR  |  6   | register-register ALU op
// EXECI  |  7   | register-immediate ALU op
// ALUWB  |  8   | ALU result -> rd
// BRANCH |  9   | compare rs1/rs2, take DECODE target if Cond_Chk
// JAL    | 10   | PC+4 -> rd, DECODE target -> PC
// TRAP   | 11   | illegal opcode, halted until reset
module multicycle_ctrl_fsm #(
  parameter int WAIT_LIMIT = 16,
  parameter int STATE_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               Cond_Chk,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MtoR,
  output logic               IRWrite,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic               RegWrite,
  output logic               Branch,
  output logic               PCWrite,
  output logic               PCEn,
  output logic [2:0]         AluControl,
  output logic [STATE_W-1:0] state_o,
  output logic               instr_done,
  output logic               bus_err
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWR  = STATE_W'(4),
    S_MEMWB  = STATE_W'(5),
    S_EXECR  = STATE_W'(6),
    S_EXECI  = STATE_W'(7),
    S_ALUWB  = STATE_W'(8),
    S_BRANCH = STATE_W'(9),
    S_JAL    = STATE_W'(10),
    S_TRAP   = STATE_W'(11)
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_state;
  logic       timeout;
  logic       op_known;
  logic       unused_funct7;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`endif

  // Only funct7[5] (sub vs add) matters to this controller.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_dec = sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b100:  alu_dec = ALU_XOR;
      3'b010:  alu_dec = ALU_SLT;
      3'b001:  alu_dec = ALU_SLL;
      3'b101:  alu_dec = ALU_SRL;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // A mem_ready on the limit cycle completes the access instead of timing out.
  assign timeout   = mem_state && !mem_ready && (wait_cnt_q == LIMIT_M1);
  assign op_known  = (opcode == OP_LOAD) || (opcode == OP_STORE) || (opcode == OP_RTYPE) ||
                     (opcode == OP_ITYPE) || (opcode == OP_BRANCH) || (opcode == OP_JAL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWR:  if (mem_ready || timeout) state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // A FETCH timeout stays in FETCH, so the counter is also cleared on timeout.
  assign wait_cnt_d = ((state_d != state_q) || timeout) ? 8'd0 :
                      (mem_state ? wait_cnt_q + 8'd1 : wait_cnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= illegal_q | (state_d == S_TRAP);
`endif
    end
  end

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    MtoR       = 1'b0;
    IRWrite    = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = 2'b00;
    RegWrite   = 1'b0;
    Branch     = 1'b0;
    PCWrite    = 1'b0;
    AluControl = ALU_ADD;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        AluSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        AluSrcB = 2'b10;
`ifndef ILLEGAL_TRAP_EN
        instr_done = !op_known;
`endif
      end
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_MEMWB: begin
        MtoR       = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        AluSrcA    = 1'b1;
        AluControl = alu_dec(funct3, funct7[5]);
      end
      S_EXECI: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 2'b10;
        AluControl = alu_dec(funct3, 1'b0);
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA    = 1'b1;
        AluControl = ALU_SUB;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        AluSrcB    = 2'b01;
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    bus_err = timeout;
    // While reset is held nothing may strobe, even if mem_ready is high.
    if (reset) begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      MtoR       = 1'b0;
      IRWrite    = 1'b0;
      AluSrcA    = 1'b0;
      AluSrcB    = 2'b00;
      RegWrite   = 1'b0;
      Branch     = 1'b0;
      PCWrite    = 1'b0;
      AluControl = ALU_ADD;
      instr_done = 1'b0;
      bus_err    = 1'b0;
    end
    PCEn = PCWrite | (Branch & Cond_Chk);
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
  localparam int WL = 16;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWR = 4'd4, S_MEMWB = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  // ALU code selected by funct3 (index), before the add/sub override.
  localparam logic [2:0] ALU_BY_F3 [8] = '{3'b000, 3'b110, 3'b101, 3'b000,
                                           3'b100, 3'b111, 3'b011, 3'b010};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Cond_Chk, mem_ready;
  logic       IorD, MemWrite, MtoR, IRWrite, AluSrcA, RegWrite, Branch, PCWrite, PCEn;
  logic [1:0] AluSrcB;
  logic [2:0] AluControl;
  logic [3:0] state_o;
  logic       instr_done, bus_err;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.WAIT_LIMIT(WL), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Cond_Chk(Cond_Chk), .mem_ready(mem_ready), .IorD(IorD), .MemWrite(MemWrite),
    .MtoR(MtoR), .IRWrite(IRWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .RegWrite(RegWrite), .Branch(Branch), .PCWrite(PCWrite), .PCEn(PCEn),
    .AluControl(AluControl), .state_o(state_o), .instr_done(instr_done), .bus_err(bus_err)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic cond; logic rdy;
    logic [3:0] st; logic iord, memw, mtor, irw, asa; logic [1:0] asb;
    logic regw, br, pcw, pcen; logic [2:0] aluc; logic done, berr;
  } cyc_t;

  cyc_t q[$];
  int errors = 0, checks = 0;
  logic [6:0] cur_op; logic [2:0] cur_f3; logic [6:0] cur_f7; logic cur_cond;
  int n_done, n_memw, n_berr, n_iord, n_pcw, n_regw, first_done, cyc_n;

  function automatic logic [19:0] act_vec();
    return {state_o, IorD, MemWrite, MtoR, IRWrite, AluSrcA, AluSrcB, RegWrite,
            Branch, PCWrite, PCEn, AluControl, instr_done, bus_err};
  endfunction

  function automatic logic [19:0] exp_vec(input cyc_t c);
    return {c.st, c.iord, c.memw, c.mtor, c.irw, c.asa, c.asb, c.regw,
            c.br, c.pcw, c.pcen, c.aluc, c.done, c.berr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d, t=%0t)", name, act, exp, cyc_n, $time);
    end
  endtask

  function automatic cyc_t base(input logic [3:0] st);
    cyc_t c;
    c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7; c.cond = cur_cond; c.rdy = 1'b1;
    c.st = st; c.iord = 0; c.memw = 0; c.mtor = 0; c.irw = 0; c.asa = 0; c.asb = 2'b00;
    c.regw = 0; c.br = 0; c.pcw = 0; c.pcen = 0; c.aluc = 3'b000; c.done = 0; c.berr = 0;
    return c;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic [6:0] f7, input bit is_r);
    if (is_r && f3 == 3'b000 && f7[5]) return 3'b001;
    return ALU_BY_F3[f3];
  endfunction

  // A memory wait phase: nwait cycles without mem_ready, then completion,
  // unless the wait limit is hit first.
  task automatic mem_phase(input logic [3:0] st, input int nwait, output bit ok);
    cyc_t c;
    ok = 1'b0;
    for (int i = 0; i < WL; i++) begin
      c = base(st);
      c.rdy  = (i >= nwait);
      c.iord = (st != S_FETCH);
      c.memw = (st == S_MEMWR);
      if (st == S_FETCH) c.asb = 2'b01;
      if (c.rdy) begin
        if (st == S_FETCH) begin c.irw = 1; c.pcw = 1; c.pcen = 1; end
        if (st == S_MEMWR) c.done = 1;
        q.push_back(c);
        ok = 1'b1;
        return;
      end
      if (i == WL - 1) c.berr = 1;
      q.push_back(c);
    end
  endtask

  task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic cond, input int fw, input int mw);
    cyc_t c;
    bit ok;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_cond = cond;
    mem_phase(S_FETCH, fw, ok);
    if (!ok) return;
    c = base(S_DECODE);
    c.asb = 2'b10;
    case (op)
      OP_LOAD, OP_STORE: begin
        q.push_back(c);
        c = base(S_MEMADR); c.asa = 1; c.asb = 2'b10; q.push_back(c);
        mem_phase((op == OP_LOAD) ? S_MEMRD : S_MEMWR, mw, ok);
        if (ok && op == OP_LOAD) begin
          c = base(S_MEMWB); c.mtor = 1; c.regw = 1; c.done = 1; q.push_back(c);
        end
      end
      OP_R, OP_I: begin
        q.push_back(c);
        c = base((op == OP_R) ? S_EXECR : S_EXECI);
        c.asa = 1;
        c.asb = (op == OP_R) ? 2'b00 : 2'b10;
        c.aluc = exp_alu(f3, f7, op == OP_R);
        q.push_back(c);
        c = base(S_ALUWB); c.regw = 1; c.done = 1; q.push_back(c);
      end
      OP_BR: begin
        q.push_back(c);
        c = base(S_BRANCH); c.asa = 1; c.aluc = 3'b001; c.br = 1; c.pcen = cond; c.done = 1;
        q.push_back(c);
      end
      OP_JAL: begin
        q.push_back(c);
        c = base(S_JAL); c.asb = 2'b01; c.regw = 1; c.pcw = 1; c.pcen = 1; c.done = 1;
        q.push_back(c);
      end
      default: begin
        c.done = 1;
        q.push_back(c);
      end
    endcase
  endtask

  task automatic seg_start();
    n_done = 0; n_memw = 0; n_berr = 0; n_iord = 0; n_pcw = 0; n_regw = 0;
    first_done = 0; cyc_n = 0;
  endtask

  // Called at a falling edge: drive inputs, compare, step to the next falling edge.
  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode = c.op; funct3 = c.f3; funct7 = c.f7; Cond_Chk = c.cond; mem_ready = c.rdy;
      #1;
      cyc_n++;
      check("cycle_outputs", {12'h0, act_vec()}, {12'h0, exp_vec(c)});
      n_done += int'(instr_done);
      n_memw += int'(MemWrite);
      n_berr += int'(bus_err);
      n_iord += int'(IorD);
      n_pcw  += int'(PCWrite);
      n_regw += int'(RegWrite);
      if (instr_done && first_done == 0) first_done = cyc_n;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_t c;
    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Cond_Chk = 1'b1; mem_ready = 1'b1;
    cur_op = 7'd0; cur_f3 = 3'd0; cur_f7 = 7'd0; cur_cond = 1'b0;
    seg_start();
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {12'h0, act_vec()}, 32'h0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; Cond_Chk = 1'b0;
    #1;
    c = base(S_FETCH); c.asb = 2'b01;
    check("fetch_idle", {12'h0, act_vec()}, {12'h0, exp_vec(c)});

    seg_start();
    plan_instr(OP_R, 3'b000, 7'b0000000, 1'b0, 0, 0);
    run_queue();
    check("radd_done_cycle", first_done, 4);
    check("radd_done_count", n_done, 1);

    plan_instr(OP_R, 3'b000, 7'b0100000, 1'b0, 0, 0);
    plan_instr(OP_I, 3'b000, 7'b0100000, 1'b0, 1, 0);
    plan_instr(OP_R, 3'b111, 7'b0000000, 1'b0, 0, 0);
    plan_instr(OP_R, 3'b110, 7'b0000000, 1'b0, 0, 0);
    plan_instr(OP_R, 3'b100, 7'b0000000, 1'b0, 0, 0);
    plan_instr(OP_R, 3'b010, 7'b0000000, 1'b0, 0, 0);
    plan_instr(OP_R, 3'b001, 7'b0000000, 1'b0, 0, 0);
    plan_instr(OP_R, 3'b101, 7'b0100000, 1'b0, 0, 0);
    plan_instr(OP_I, 3'b100, 7'b0000000, 1'b0, 0, 0);
    plan_instr(OP_I, 3'b101, 7'b0100000, 1'b0, 0, 0);
    run_queue();

    seg_start();
    plan_instr(OP_LOAD, 3'b010, 7'd0, 1'b0, 2, 3);
    run_queue();
    check("lw_iord_cycles", n_iord, 4);
    check("lw_regwrite", n_regw, 1);

    plan_instr(OP_STORE, 3'b010, 7'd0, 1'b0, 0, 1);
    plan_instr(OP_BR, 3'b000, 7'd0, 1'b1, 0, 0);
    run_queue();

    seg_start();
    plan_instr(OP_BR, 3'b000, 7'd0, 1'b0, 0, 0);
    run_queue();
    check("beq_nt_pcwrite", n_pcw, 1);

    plan_instr(OP_JAL, 3'b000, 7'd0, 1'b0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
    plan_instr(7'b0000000, 3'b000, 7'd0, 1'b0, 0, 0);
`endif
    run_queue();

    seg_start();
    plan_instr(OP_STORE, 3'b010, 7'd0, 1'b0, 0, 100);
    run_queue();
    check("sw_stuck_memwrite", n_memw, 16);
    check("sw_stuck_buserr", n_berr, 1);
    check("sw_stuck_regwrite", n_regw, 0);
    check("sw_stuck_done", n_done, 0);

    seg_start();
    plan_instr(OP_R, 3'b000, 7'd0, 1'b0, WL - 1, 0);
    run_queue();
    check("fetch_ready_at_limit", n_berr, 0);
    seg_start();
    plan_instr(OP_R, 3'b000, 7'd0, 1'b0, WL, 0);
    plan_instr(OP_R, 3'b100, 7'd0, 1'b0, 0, 0);
    run_queue();
    check("fetch_timeout_buserr", n_berr, 1);
    check("fetch_timeout_done", n_done, 1);

    plan_instr(OP_STORE, 3'b010, 7'd0, 1'b0, 0, 100);
    while (q.size() > 6) void'(q.pop_back());
    run_queue();
    #1;
    check("memwr_before_reset", {31'd0, MemWrite}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("reset_memwrite", {31'd0, MemWrite}, 32'd0);
    check("reset_state", {28'd0, state_o}, {28'd0, S_FETCH});
    check("reset_strobes", {28'd0, RegWrite, PCEn, IRWrite, bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seg_start();
    plan_instr(OP_R, 3'b000, 7'd0, 1'b0, WL - 2, 0);
    run_queue();
    check("post_reset_no_buserr", n_berr, 0);
    check("post_reset_done", n_done, 1);

`ifdef ILLEGAL_TRAP_EN
    begin
      bit ok;
      cur_op = 7'b1111111; cur_f3 = 3'd0; cur_f7 = 7'd0; cur_cond = 1'b0;
      mem_phase(S_FETCH, 0, ok);
      c = base(S_DECODE); c.asb = 2'b10; q.push_back(c);
      run_queue();
      #1;
      check("trap_state", {28'd0, state_o}, {28'd0, S_TRAP});
      check("trap_illegal", {31'd0, illegal}, 32'd1);
      repeat (3) @(negedge clk);
      #1;
      check("trap_illegal_sticky", {31'd0, illegal}, 32'd1);
      check("trap_strobes", {28'd0, RegWrite, PCEn, MemWrite, IRWrite}, 32'd0);
      reset = 1'b1;
      #1;
      check("trap_reset_clears", {31'd0, illegal}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
